// File: rtl/mcu_console_fifo.sv
// MCU-to-console data FIFO with synchronised console strobes, level tracking,
// refill watermark, sticky overflow/underflow flags and a show-ahead head word.
module mcu_console_fifo #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned LOW_WATER   = 0,
  parameter int unsigned SWAP_BYTES  = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     CLK_MCU,
  input  logic                     nRESET,
  input  logic                     MCU_WR,
  input  logic [WIDTH-1:0]         MCU_DIN,
  input  logic                     CON_RD_ASYNC,
  input  logic                     CON_FLUSH_ASYNC,
  input  logic                     STAT_CLR,
  output logic [WIDTH-1:0]         CON_DOUT,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     REFILL_REQ,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;

  localparam lvl_t LVL_FULL = lvl_t'(DEPTH);
  localparam lvl_t LVL_LOW  = lvl_t'(LOW_WATER);

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr, rd_ptr;
  ptr_t wr_ptr_nxt, rd_ptr_nxt;
  lvl_t level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] wr_data;

  logic [SYNC_STAGES-1:0] rd_sync, flush_sync;
  logic rd_last, flush_last;
  logic pop_ev, flush_ev;
  logic pop_ok, pop_empty, push_ok, push_drop;

  generate
    if (SWAP_BYTES != 0) begin : g_swap
      assign wr_data = {MCU_DIN[WIDTH/2-1:0], MCU_DIN[WIDTH-1:WIDTH/2]};
    end else begin : g_noswap
      assign wr_data = MCU_DIN;
    end
  endgenerate

  always_ff @(posedge CLK_MCU or negedge nRESET) begin
    if (!nRESET) begin
      rd_sync    <= '0;
      flush_sync <= '0;
      rd_last    <= 1'b0;
      flush_last <= 1'b0;
    end else begin
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], CON_RD_ASYNC};
      flush_sync <= {flush_sync[SYNC_STAGES-2:0], CON_FLUSH_ASYNC};
      rd_last    <= rd_sync[SYNC_STAGES-1];
      flush_last <= flush_sync[SYNC_STAGES-1];
    end
  end

  // Pop on the end of the console access so the head is stable while sampled.
  assign pop_ev   = rd_last & ~rd_sync[SYNC_STAGES-1];
  assign flush_ev = flush_sync[SYNC_STAGES-1] & ~flush_last;

  assign pop_ok    = pop_ev & ~flush_ev & ~EMPTY;
  assign pop_empty = pop_ev & ~flush_ev & EMPTY;
  assign push_ok   = MCU_WR & ~flush_ev & (~FULL | pop_ok);
  assign push_drop = MCU_WR & ~flush_ev & FULL & ~pop_ok;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = LEVEL;
    if (flush_ev) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + ptr_t'(1);
      if (pop_ok)  rd_ptr_nxt = rd_ptr + ptr_t'(1);
      if (push_ok && !pop_ok)      level_nxt = LEVEL + lvl_t'(1);
      else if (pop_ok && !push_ok) level_nxt = LEVEL - lvl_t'(1);
    end
  end

  // The word written this cycle is not yet in mem, so bypass it when it becomes the head.
  always_comb begin
    head_nxt = CON_DOUT;
    if (flush_ev) begin
      head_nxt = mem[rd_ptr_nxt];
    end else if ((pop_ok || EMPTY) && level_nxt != '0) begin
      if (push_ok && wr_ptr == rd_ptr_nxt) head_nxt = wr_data;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge CLK_MCU) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK_MCU or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      LEVEL      <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      CON_DOUT   <= '0;
      REFILL_REQ <= 1'b0;
      OVERFLOW   <= 1'b0;
      UNDERFLOW  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      LEVEL    <= level_nxt;
      FULL     <= (level_nxt == LVL_FULL);
      EMPTY    <= (level_nxt == '0);
      CON_DOUT <= head_nxt;

      if (flush_ev || (pop_ok && level_nxt <= LVL_LOW)) REFILL_REQ <= 1'b1;
      else if (level_nxt == LVL_FULL)                   REFILL_REQ <= 1'b0;

      if (push_drop)     OVERFLOW <= 1'b1;
      else if (STAT_CLR) OVERFLOW <= 1'b0;

      if (pop_empty)     UNDERFLOW <= 1'b1;
      else if (STAT_CLR) UNDERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcu_console_fifo.sv
// Randomised and directed bench for mcu_console_fifo against a queue-based reference model.
module tb_mcu_console_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LOW_W = 2;
  localparam int unsigned SYNC  = 2;

  logic             CLK_MCU = 1'b0;
  logic             nRESET = 1'b0;
  logic             MCU_WR = 1'b0;
  logic [WIDTH-1:0] MCU_DIN = '0;
  logic             CON_RD_ASYNC = 1'b0;
  logic             CON_FLUSH_ASYNC = 1'b0;
  logic             STAT_CLR = 1'b0;
  logic [WIDTH-1:0] CON_DOUT;
  logic [3:0]       LEVEL;
  logic             FULL, EMPTY, REFILL_REQ, OVERFLOW, UNDERFLOW;

  mcu_console_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOW_WATER(LOW_W), .SWAP_BYTES(1), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK_MCU(CLK_MCU), .nRESET(nRESET), .MCU_WR(MCU_WR), .MCU_DIN(MCU_DIN),
    .CON_RD_ASYNC(CON_RD_ASYNC), .CON_FLUSH_ASYNC(CON_FLUSH_ASYNC), .STAT_CLR(STAT_CLR),
    .CON_DOUT(CON_DOUT), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY),
    .REFILL_REQ(REFILL_REQ), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK_MCU = ~CLK_MCU;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit               rd_log[$];
  bit               fl_log[$];
  int               cyc_idx;
  logic [WIDTH-1:0] dout_m;
  bit               dout_known;
  bit               refill_m, ovf_m, unf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] swap(input logic [WIDTH-1:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic bit log_at(input bit lg[$], input int i);
    if (i < 0 || i >= lg.size()) return 1'b0;
    return lg[i];
  endfunction

  task automatic model_reset();
    q.delete();
    rd_log.delete();
    fl_log.delete();
    cyc_idx    = 0;
    dout_m     = '0;
    dout_known = 1'b1;
    refill_m   = 1'b0;
    ovf_m      = 1'b0;
    unf_m      = 1'b0;
  endtask

  // One clock edge of the reference: events are the strobe history delayed by the synchroniser depth.
  task automatic model_edge();
    bit pop, fl, popv, pushok;
    int c;
    c = cyc_idx;
    rd_log.push_back(CON_RD_ASYNC);
    fl_log.push_back(CON_FLUSH_ASYNC);
    cyc_idx++;
    pop = log_at(rd_log, c - SYNC - 1) && !log_at(rd_log, c - SYNC);
    fl  = log_at(fl_log, c - SYNC) && !log_at(fl_log, c - SYNC - 1);
    if (STAT_CLR) begin
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end
    if (fl) begin
      q.delete();
      refill_m   = 1'b1;
      dout_known = 1'b0;
    end else begin
      popv   = pop && q.size() > 0;
      pushok = MCU_WR && (q.size() < DEPTH || popv);
      if (pop && q.size() == 0) unf_m = 1'b1;
      if (MCU_WR && !pushok)    ovf_m = 1'b1;
      if (popv)   void'(q.pop_front());
      if (pushok) q.push_back(swap(MCU_DIN));
      if (popv && q.size() <= LOW_W) refill_m = 1'b1;
      else if (q.size() == DEPTH)    refill_m = 1'b0;
    end
    if (q.size() > 0) begin
      dout_m     = q[0];
      dout_known = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("level", 32'(LEVEL), 32'(q.size()));
    check("full", 32'(FULL), 32'(q.size() == DEPTH));
    check("empty", 32'(EMPTY), 32'(q.size() == 0));
    check("refill", 32'(REFILL_REQ), 32'(refill_m));
    check("overflow", 32'(OVERFLOW), 32'(ovf_m));
    check("underflow", 32'(UNDERFLOW), 32'(unf_m));
    if (dout_known) check("dout", 32'(CON_DOUT), 32'(dout_m));
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks, returns at next falling edge.
  task automatic cyc(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit fl, input bit clr);
    MCU_WR = wr;
    MCU_DIN = d;
    CON_RD_ASYNC = rd;
    CON_FLUSH_ASYNC = fl;
    STAT_CLR = clr;
    @(posedge CLK_MCU);
    model_edge();
    #1;
    compare_all();
    @(negedge CLK_MCU);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_pulse();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic do_reset();
    @(negedge CLK_MCU);
    nRESET = 1'b0;
    MCU_WR = 1'b0;
    MCU_DIN = '0;
    CON_RD_ASYNC = 1'b0;
    CON_FLUSH_ASYNC = 1'b0;
    STAT_CLR = 1'b0;
    #1;
    model_reset();
    check("rst_level", 32'(LEVEL), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_dout", 32'(CON_DOUT), 32'd0);
    check("rst_flags", {29'd0, REFILL_REQ, OVERFLOW, UNDERFLOW}, 32'd0);
    repeat (2) @(negedge CLK_MCU);
    nRESET = 1'b1;
  endtask

  initial begin
    bit rd_s, fl_s;
    do_reset();

    // Byte swap and show-ahead head
    push(16'h1234);
    push(16'hABCD);
    idle(1);
    check("tp1_level", 32'(LEVEL), 32'd2);
    check("tp1_dout", 32'(CON_DOUT), 32'h3412);
    rd_pulse();
    check("tp1_dout_pop", 32'(CON_DOUT), 32'hCDAB);
    check("tp1_level_pop", 32'(LEVEL), 32'd1);

    // Overflow on the ninth word
    do_reset();
    for (int i = 0; i < 9; i++) push(16'h0100 + 16'(i));
    check("tp2_full", 32'(FULL), 32'd1);
    check("tp2_level", 32'(LEVEL), 32'd8);
    check("tp2_ovf", 32'(OVERFLOW), 32'd1);
    check("tp2_head", 32'(CON_DOUT), 32'h0001);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("tp2_ovf_clr", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 8; i++) rd_pulse();
    check("tp2_last", 32'(CON_DOUT), 32'h0701);
    check("tp2_empty", 32'(EMPTY), 32'd1);

    // Underflow leaves the head word alone
    rd_pulse();
    check("tp3_unf", 32'(UNDERFLOW), 32'd1);
    check("tp3_level", 32'(LEVEL), 32'd0);
    check("tp3_dout", 32'(CON_DOUT), 32'h0701);

    // Flush and refill request
    do_reset();
    for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("tp4_level", 32'(LEVEL), 32'd0);
    check("tp4_empty", 32'(EMPTY), 32'd1);
    check("tp4_refill", 32'(REFILL_REQ), 32'd1);
    for (int i = 0; i < 7; i++) push(16'h3000 + 16'(i));
    check("tp4_refill7", 32'(REFILL_REQ), 32'd1);
    push(16'h3007);
    check("tp4_refill8", 32'(REFILL_REQ), 32'd0);
    check("tp4_level8", 32'(LEVEL), 32'd8);
    check("tp4_head", 32'(CON_DOUT), 32'h0030);

    // Watermark at LEVEL=2
    for (int i = 1; i <= 6; i++) begin
      rd_pulse();
      check("tp5_level", 32'(LEVEL), 32'(8 - i));
      check("tp5_refill", 32'(REFILL_REQ), 32'((8 - i) <= 2));
    end

    // Push coincident with a pop at full, then with a flush
    for (int i = 0; i < 6; i++) push(16'h4000 + 16'(i));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    push(16'h5555);
    check("tp6_level", 32'(LEVEL), 32'd8);
    check("tp6_ovf", 32'(OVERFLOW), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h6666, 1'b0, 1'b1, 1'b0);
    check("tp6_flush_level", 32'(LEVEL), 32'd0);
    check("tp6_flush_ovf", 32'(OVERFLOW), 32'd0);
    idle(3);

    // Random traffic
    rd_s = 1'b0;
    fl_s = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      if ($urandom_range(0, 3) == 0) rd_s = ~rd_s;
      if (fl_s) fl_s = ($urandom_range(0, 1) == 0);
      else      fl_s = ($urandom_range(0, 79) == 0);
      cyc($urandom_range(0, 1) == 1, 16'($urandom), rd_s, fl_s, $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
